sm4_round_engine: RTL and testbench
===================================

Name: sm4_round_engine

Overview:
- Iterative SM4 cipher datapath, directly downstream of the key-expansion stage; consumes its 32 round keys and its completion flag.
- Round keys arrive already ordered for the operation, so this block has no enc/dec input. Encryption and decryption are the same datapath.
- Processes one 128-bit block at a time, one round per clock. Result is registered with a single-cycle valid pulse to the output/bus stage.

Parameters:
- ROUNDS, 32, number of rounds executed. Must be 32 for standard SM4; smaller values are for debug only and use rk_0..rk_(ROUNDS-1).

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- sm4_enable  in  1  global core enable; low aborts any operation
- key_ready  in  1  key expansion finished; round keys stable
- rk_flat  in  1024  round keys; rk_i = rk_flat[32*i+31:32*i], i=0..31, applied in round i
- in_valid  in  1  data_in valid
- in_ready  out  1  block can accept data_in this cycle
- data_in  in  128  input block X0..X3, X0 = data_in[127:96]
- data_out  out  128  result block
- out_valid  out  1  one-cycle pulse; data_out holds a new result
- busy  out  1  rounds in progress

Behaviour:
- Reset (rst_n low, asynchronous):
  - state = IDLE, round counter = 0, internal X regs = 0.
  - data_out = 0, out_valid = 0, busy = 0.
  - in_ready follows the combinational rule below.
- in_ready = (state==IDLE) && sm4_enable && key_ready. Combinational, no dependency on in_valid.
- Accept: on an edge where in_valid && in_ready:
  - load X0..X3 from data_in, counter = 0, state goes to RUN.
  - in_valid without in_ready is ignored (no buffering); the upstream stage holds data.
- RUN: each edge computes one round i = counter.
  - New word = X0 ^ T(X1 ^ X2 ^ X3 ^ rk_i).
  - Shift: (X0,X1,X2,X3) becomes (X1,X2,X3,new).
  - counter increments.
- T function:
  - tau: four parallel 8-bit S-box lookups.
  - L(B) = B ^ (B<<<2) ^ (B<<<10) ^ (B<<<18) ^ (B<<<24).
  - All arithmetic is 32-bit XOR and rotate; no carries.
- On the edge processing round ROUNDS-1:
  - data_out is loaded with the reverse transform (X35,X34,X33,X32), i.e. {new, X3, X2, X1} of that cycle.
  - out_valid = 1 for exactly the following cycle; state goes to IDLE.
- Latency: accept at edge E0; rounds at E1..E32; out_valid high in the cycle after E32.
  - Next block may be accepted at E33. Throughput is 1 block per 33 clocks.
- busy = (state==RUN). in_ready is low whenever busy.
- data_out holds its value until the next completion; out_valid is never high two cycles in a row.
- Key stability:
  - rk_flat and key_ready are sampled every round, not latched.
  - key_ready falling during RUN does not stall or abort; the upstream stage guarantees keys are stable while busy.
- sm4_enable low (any state), synchronous effect:
  - next edge forces IDLE, counter = 0, out_valid = 0.
  - data_out retains its previous value.
  - No partial result is ever reported.
- sm4_enable low on the same edge as the final round: abort wins, no out_valid.
- rst_n asserted mid-RUN: immediate return to reset values. No output pulse after release.

Decomposition:
- Shared package sm4_pkg:
  - SBOX constant (256 x 8-bit, standard SM4 table)
  - SM4_ROUNDS = 32
  - state encoding typedef (IDLE, RUN)
  - rk slice helper function
- Sub-module sm4_t_func: combinational 32-bit T transform (4 S-box lookups + L). Instanced once.
- Key-expansion's T' (L' rotations 13/23) is separate and not shared.

Test Plan:
- Standard encryption vector:
  - Key 0123456789abcdeffedcba9876543210 round keys (rk_0=f12186f9 … rk_31=9124a012).
  - data_in 0123456789abcdeffedcba9876543210.
  - Expect data_out 681edf34d206965e86b3e94f536e4246, out_valid in the cycle after E32.
- Decryption: same keys in reversed order, data_in 681edf34d206965e86b3e94f536e4246 -> data_out 0123456789abcdeffedcba9876543210.
- key_ready=0 with in_valid=1 for 10 cycles:
  - in_ready=0, no accept.
  - Raise key_ready: accept on that edge, result exactly 32 edges later.
- Back-to-back: hold in_valid=1 with two blocks.
  - Second accepted at E33.
  - Two out_valid pulses 33 cycles apart, both correct, never high two cycles in a row.
- Abort: drop sm4_enable at round 15 for 1 cycle.
  - busy=0 next cycle, no out_valid, data_out unchanged.
  - Re-issue block: correct result.
- Async reset mid-RUN (round 20): outputs zero immediately. After release, a fresh block gives the correct ciphertext.

Source files
------------

// File: rtl/sm4_pkg.sv
// Shared SM4 constants, state encoding and small helpers used by the round engine.
package sm4_pkg;

  localparam int unsigned SM4_ROUNDS = 32;

  typedef enum logic [0:0] {StIdle, StRun} sm4_state_e;

  // Standard SM4 S-box, entry 0 in the most significant byte.
  localparam logic [2047:0] SBOX_FLAT = {
    128'hd690e9fecce13db716b614c228fb2c05,
    128'h2b679a762abe04c3aa44132649860699,
    128'h9c4250f491ef987a33540b43edcfac62,
    128'he4b31ca9c908e89580df94fa758f3fa6,
    128'h4707a7fcf37317ba83593c19e6854fa8,
    128'h686b81b27164da8bf8eb0f4b70569d35,
    128'h1e240e5e6358d1a225227c3b01217887,
    128'hd40046579fd327524c3602e7a0c4c89e,
    128'heabf8ad240c738b5a3f7f2cef96115a1,
    128'he0ae5da49b341a55ad933230f58cb1e3,
    128'h1df6e22e8266ca60c02923ab0d534e6f,
    128'hd5db3745defd8e2f03ff6a726d6c5b51,
    128'h8d1baf92bbddbc7f11d95c411f105ad8,
    128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
    128'h8969974a0c96777e65b9f109c56ec684,
    128'h18f07dec3adc4d2079ee5f3ed7cb3948
  };

  function automatic logic [7:0] sbox_lookup(input logic [7:0] x);
    return SBOX_FLAT[2047 - 8 * int'(x) -: 8];
  endfunction

  // Round key i lives in rk_flat[32*i+31:32*i].
  function automatic logic [31:0] rk_slice(input logic [1023:0] rk_flat, input logic [4:0] idx);
    return rk_flat[32 * int'(idx) +: 32];
  endfunction

endpackage

// File: rtl/sm4_round_engine_if.sv
// Handshake, key and data bus between key expansion / host and the SM4 round engine.
interface sm4_round_engine_if;
  logic           sm4_enable;
  logic           key_ready;
  logic [1023:0]  rk_flat;
  logic           in_valid;
  logic           in_ready;
  logic [127:0]   data_in;
  logic [127:0]   data_out;
  logic           out_valid;
  logic           busy;

  modport master (
    output sm4_enable, key_ready, rk_flat, in_valid, data_in,
    input  in_ready, data_out, out_valid, busy
  );

  modport slave (
    input  sm4_enable, key_ready, rk_flat, in_valid, data_in,
    output in_ready, data_out, out_valid, busy
  );
endinterface

// File: rtl/sm4_t_func.sv
// SM4 round transform T = L(tau(a)): four S-box lookups followed by the linear mix.
module sm4_t_func
  import sm4_pkg::*;
(
  input  logic [31:0] a_i,
  output logic [31:0] t_o
);

  logic [31:0] b;

  // Non-linear byte substitution then L(B) = B ^ B<<<2 ^ B<<<10 ^ B<<<18 ^ B<<<24.
  always_comb begin
    b   = {sbox_lookup(a_i[31:24]), sbox_lookup(a_i[23:16]),
           sbox_lookup(a_i[15:8]),  sbox_lookup(a_i[7:0])};
    t_o = b ^ {b[29:0], b[31:30]} ^ {b[21:0], b[31:22]} ^
          {b[13:0], b[31:14]} ^ {b[7:0], b[31:8]};
  end

endmodule

// File: rtl/sm4_round_engine.sv
// Iterative SM4 datapath: one round per clock, registered result with a one-cycle valid pulse.
module sm4_round_engine
  import sm4_pkg::*;
#(
  parameter int unsigned ROUNDS = SM4_ROUNDS
) (
  input logic                clk,
  input logic                rst_n,
  sm4_round_engine_if.slave  bus
);

  localparam logic [4:0] LastRound = 5'(ROUNDS - 1);

  sm4_state_e   state_q;
  logic [4:0]   cnt_q;
  logic [127:0] x_q;         // {X0, X1, X2, X3}, X0 in the top word
  logic [127:0] data_out_q;
  logic         out_valid_q;
  logic         in_ready;
  logic [31:0]  t_out;
  logic [31:0]  new_word;

  assign in_ready = (state_q == StIdle) && bus.sm4_enable && bus.key_ready;

  sm4_t_func u_t_func (
    .a_i (x_q[95:64] ^ x_q[63:32] ^ x_q[31:0] ^ rk_slice(bus.rk_flat, cnt_q)),
    .t_o (t_out)
  );

  assign new_word = x_q[127:96] ^ t_out;

  // Control FSM and datapath registers; disable has priority over every other action.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      x_q         <= '0;
      data_out_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (!bus.sm4_enable) begin
        state_q <= StIdle;
        cnt_q   <= '0;
      end else begin
        unique case (state_q)
          StIdle: begin
            if (bus.in_valid && in_ready) begin
              x_q     <= bus.data_in;
              cnt_q   <= '0;
              state_q <= StRun;
            end
          end
          StRun: begin
            x_q   <= {x_q[95:0], new_word};
            cnt_q <= cnt_q + 5'd1;
            if (cnt_q == LastRound) begin
              // Reverse transform: (X35, X34, X33, X32).
              data_out_q  <= {new_word, x_q[31:0], x_q[63:32], x_q[95:64]};
              out_valid_q <= 1'b1;
              cnt_q       <= '0;
              state_q     <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.data_out  = data_out_q;
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = (state_q == StRun);

endmodule

// File: tb/tb_sm4_round_engine.sv
// Scoreboard bench for sm4_round_engine: driver pushes expected results, monitor pops on out_valid.
module tb_sm4_round_engine;
  import sm4_pkg::*;

  typedef struct {
    logic [127:0] data;
    int           cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  sm4_round_engine_if bus ();

  sm4_round_engine #(.ROUNDS(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- reference model ----------------
  function automatic logic [31:0] rotl(input logic [31:0] x, input int n);
    return (x << n) | (x >> (32 - n));
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] x);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*j +: 8] = sbox_lookup(x[8*j +: 8]);
    return r;
  endfunction

  function automatic logic [31:0] t_enc(input logic [31:0] x);
    logic [31:0] b;
    b = tau(x);
    return b ^ rotl(b, 2) ^ rotl(b, 10) ^ rotl(b, 18) ^ rotl(b, 24);
  endfunction

  function automatic logic [31:0] t_key(input logic [31:0] x);
    logic [31:0] b;
    b = tau(x);
    return b ^ rotl(b, 13) ^ rotl(b, 23);
  endfunction

  function automatic logic [1023:0] key_expand(input logic [127:0] key);
    logic [31:0]   fk [4];
    logic [31:0]   k [36];
    logic [31:0]   ck;
    logic [1023:0] rkf;
    fk[0] = 32'ha3b1bac6; fk[1] = 32'h56aa3350; fk[2] = 32'h677d9197; fk[3] = 32'hb27022dc;
    for (int i = 0; i < 4; i++) k[i] = key[127 - 32*i -: 32] ^ fk[i];
    for (int i = 0; i < 32; i++) begin
      for (int j = 0; j < 4; j++) ck[31 - 8*j -: 8] = 8'((4*i + j) * 7);
      k[i+4] = k[i] ^ t_key(k[i+1] ^ k[i+2] ^ k[i+3] ^ ck);
      rkf[32*i +: 32] = k[i+4];
    end
    return rkf;
  endfunction

  function automatic logic [1023:0] reverse_keys(input logic [1023:0] rkf);
    logic [1023:0] r;
    for (int i = 0; i < 32; i++) r[32*i +: 32] = rkf[32*(31-i) +: 32];
    return r;
  endfunction

  function automatic logic [127:0] cipher(input logic [127:0] blk, input logic [1023:0] rkf);
    logic [31:0] x [36];
    for (int i = 0; i < 4; i++) x[i] = blk[127 - 32*i -: 32];
    for (int i = 0; i < 32; i++)
      x[i+4] = x[i] ^ t_enc(x[i+1] ^ x[i+2] ^ x[i+3] ^ rkf[32*i +: 32]);
    return {x[35], x[34], x[33], x[32]};
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Drive a block and wait (bounded) until it is accepted; optionally queue its expected result.
  task automatic send(input logic [127:0] blk, input bit push, input logic [127:0] exp,
                      input bit raise_key, output int acc);
    int waited;
    waited = 0;
    @(negedge clk);
    bus.data_in  = blk;
    bus.in_valid = 1'b1;
    if (raise_key) bus.key_ready = 1'b1;
    #1;
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk); #1;
      waited++;
    end
    if (!bus.in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL accept_timeout: in_ready stayed %b, expected 1", bus.in_ready);
      bus.in_valid = 1'b0;
      acc = -1;
    end else begin
      @(posedge clk); #1;
      acc = cyc;
      if (push) exp_q.push_back('{data: exp, cyc: acc + 32});
      bus.in_valid = 1'b0;
      check("busy_after_accept", 128'(bus.busy), 128'd1);
      check("in_ready_while_busy", 128'(bus.in_ready), 128'd0);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
    repeat (2) @(posedge clk);
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    bit   prev_ov;
    exp_t e;
    prev_ov = 1'b0;
    forever begin
      @(posedge clk); #1;
      if (bus.out_valid === 1'b1) begin
        check("out_valid_not_back_to_back", 128'(prev_ov), 128'd0);
        if (exp_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_out_valid: got data %h at cycle %0d, expected none",
                   bus.data_out, cyc);
        end else begin
          e = exp_q.pop_front();
          check("result_data", bus.data_out, e.data);
          check("result_latency", 128'(cyc), 128'(e.cyc));
        end
      end
      prev_ov = (bus.out_valid === 1'b1);
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin : stim
    logic [127:0]  key, blk, blk2, d_prev;
    logic [1023:0] rk;
    int            acc, acc2;

    rst_n          = 1'b1;
    bus.sm4_enable = 1'b1;
    bus.key_ready  = 1'b1;
    bus.in_valid   = 1'b0;
    bus.data_in    = '0;
    bus.rk_flat    = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset_data_out", bus.data_out, 128'd0);
    check("reset_out_valid", 128'(bus.out_valid), 128'd0);
    check("reset_busy", 128'(bus.busy), 128'd0);
    check("reset_in_ready", 128'(bus.in_ready), 128'd1);
    bus.key_ready = 1'b0; #1;
    check("in_ready_no_key", 128'(bus.in_ready), 128'd0);
    bus.key_ready = 1'b1; bus.sm4_enable = 1'b0; #1;
    check("in_ready_disabled", 128'(bus.in_ready), 128'd0);
    bus.sm4_enable = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Standard encryption and decryption vectors.
    key = 128'h0123456789abcdeffedcba9876543210;
    rk  = key_expand(key);
    bus.rk_flat = rk;
    send(key, 1'b1, 128'h681edf34d206965e86b3e94f536e4246, 1'b0, acc);
    drain();
    bus.rk_flat = reverse_keys(rk);
    send(128'h681edf34d206965e86b3e94f536e4246, 1'b1, key, 1'b0, acc);
    drain();

    // key_ready low blocks acceptance while in_valid is held.
    key = rand128();
    rk  = key_expand(key);
    bus.rk_flat = rk;
    blk = rand128();
    @(negedge clk);
    bus.key_ready = 1'b0;
    bus.data_in   = blk;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 10; i++) begin
      #1 check("in_ready_key_low", 128'(bus.in_ready), 128'd0);
      @(posedge clk); #1;
      check("busy_key_low", 128'(bus.busy), 128'd0);
      @(negedge clk);
    end
    send(blk, 1'b1, cipher(blk, rk), 1'b1, acc);
    drain();

    // Back-to-back blocks: second accepted 33 edges after the first.
    blk  = rand128();
    blk2 = rand128();
    send(blk, 1'b1, cipher(blk, rk), 1'b0, acc);
    send(blk2, 1'b1, cipher(blk2, rk), 1'b0, acc2);
    check("back_to_back_accept", 128'(acc2 - acc), 128'd33);
    drain();

    // Abort at round 15: no result, data_out untouched, then a clean retry.
    blk    = rand128();
    d_prev = bus.data_out;
    send(blk, 1'b0, '0, 1'b0, acc);
    repeat (16) @(negedge clk);
    bus.sm4_enable = 1'b0;
    @(posedge clk); #1;
    check("abort_busy", 128'(bus.busy), 128'd0);
    check("abort_out_valid", 128'(bus.out_valid), 128'd0);
    check("abort_data_out", bus.data_out, d_prev);
    @(negedge clk);
    bus.sm4_enable = 1'b1;
    repeat (40) @(posedge clk);
    check("abort_data_out_held", bus.data_out, d_prev);
    send(blk, 1'b1, cipher(blk, rk), 1'b0, acc);
    drain();

    // Asynchronous reset at round 20.
    blk = rand128();
    send(blk, 1'b0, '0, 1'b0, acc);
    repeat (20) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_data_out", bus.data_out, 128'd0);
    check("async_rst_out_valid", 128'(bus.out_valid), 128'd0);
    check("async_rst_busy", 128'(bus.busy), 128'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(posedge clk);
    blk = rand128();
    send(blk, 1'b1, cipher(blk, rk), 1'b0, acc);
    drain();

    // Random keys and blocks.
    for (int k = 0; k < 3; k++) begin
      key = rand128();
      rk  = key_expand(key);
      bus.rk_flat = rk;
      for (int b = 0; b < 3; b++) begin
        blk = rand128();
        send(blk, 1'b1, cipher(blk, rk), 1'b0, acc);
      end
      drain();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
